// File: rtl/axis8_pkg.sv
// Shared types for the 8-bit AXI-Stream blocks: the stored FIFO entry is {last, data}.
package axis8_pkg;

  localparam int unsigned AXIS8_DATA_W  = 8;
  localparam int unsigned AXIS8_ENTRY_W = 9;

  typedef struct packed {
    logic                    last;
    logic [AXIS8_DATA_W-1:0] data;
  } axis8_entry_t;

endpackage

// File: rtl/axis8_fifo_mem.sv
// DEPTH x 9 simple dual-port RAM: synchronous write, asynchronous read.
// Kept separate so a vendor RAM macro can be dropped in.
module axis8_fifo_mem
  import axis8_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  axis8_entry_t      i_wr_entry,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output axis8_entry_t      o_rd_entry
);

  // Contents are intentionally not reset.
  axis8_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_entry;
    end
  end

  assign o_rd_entry = r_mem[i_rd_addr];

endmodule

// File: rtl/axis8_pkt_fifo.sv
// First-word-fall-through 8-bit AXI-Stream FIFO with stored last flag and an optional
// packet mode that withholds output until a whole packet (or a full buffer) is held.
module axis8_pkt_fifo
  import axis8_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned PKT_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXIS8_DATA_W-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic [AXIS8_DATA_W-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [ADDR_W:0]         level,
  output logic [ADDR_W:0]         pkt_count
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis8_pkt_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  r_pkt_count;

  logic              w_full;
  logic              w_empty;
  logic              w_release;
  logic              w_s_ready;
  logic              w_m_valid;
  logic              w_wr;
  logic              w_rd;
  logic              w_pkt_in;
  logic              w_pkt_out;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [LVL_W-1:0]  w_pkt_nxt;
  axis8_entry_t      w_wr_entry;
  axis8_entry_t      w_head;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);

  // Packet mode: release once a complete packet is held, or when full so an
  // over-long packet cannot deadlock the buffer.
  assign w_release = (PKT_MODE == 0) || (r_pkt_count != '0) || w_full;

  assign w_s_ready = !w_full && !rst;
  assign w_m_valid = !w_empty && w_release && !rst;

  assign w_wr      = s_valid && w_s_ready;
  assign w_rd      = w_m_valid && m_ready;
  assign w_pkt_in  = w_wr && s_last;
  assign w_pkt_out = w_rd && w_head.last;

  assign w_wr_entry.last = s_last;
  assign w_wr_entry.data = s_data;

  axis8_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk        (clk),
    .i_wr_en    (w_wr),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_entry (w_wr_entry),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_entry (w_head)
  );

  // Occupancy and packet-count bookkeeping; a simultaneous in/out cancels.
  always_comb begin
    w_level_nxt = r_level;
    w_pkt_nxt   = r_pkt_count;
    if (w_wr && !w_rd) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_wr && w_rd) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
    if (w_pkt_in && !w_pkt_out) begin
      w_pkt_nxt = r_pkt_count + LVL_W'(1);
    end else if (!w_pkt_in && w_pkt_out) begin
      w_pkt_nxt = r_pkt_count - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_level     <= w_level_nxt;
      r_pkt_count <= w_pkt_nxt;
    end
  end

  assign s_ready   = w_s_ready;
  assign m_valid   = w_m_valid;
  assign m_data    = w_m_valid ? w_head.data : '0;
  assign m_last    = w_m_valid && w_head.last;
  assign level     = r_level;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis8_pkt_fifo.sv
// Bench for axis8_pkt_fifo: instance 0 streams bytes (PKT_MODE=0), instance 1 is in packet mode.
module tb_axis8_pkt_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] s_data    [2];
  logic       s_valid   [2];
  logic       s_last    [2];
  logic       m_ready   [2];
  logic       s_ready   [2];
  logic [7:0] m_data    [2];
  logic       m_valid   [2];
  logic       m_last    [2];
  logic [4:0] level     [2];
  logic [4:0] pkt_count [2];

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int npk [2];
  int nwr [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis8_pkt_fifo #(.DEPTH(16), .PKT_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_last(s_last[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0]),
    .level(level[0]), .pkt_count(pkt_count[0])
  );

  axis8_pkt_fifo #(.DEPTH(16), .PKT_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_last(s_last[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1]),
    .level(level[1]), .pkt_count(pkt_count[1])
  );

  task automatic chk(input string t, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", t, obs, exp);
    end
  endtask

  function automatic string tg(input int d, input string name);
    return $sformatf("d%0d_%s", d, name);
  endfunction

  // One clock: check both instances against the scoreboard, apply handshakes, advance.
  task automatic tick();
    logic       er, ev;
    logic [8:0] head;
    logic [8:0] popped;
    int         sz;
    #1;
    for (int d = 0; d < 2; d++) begin
      sz   = (d == 0) ? q0.size() : q1.size();
      head = 9'h000;
      if (sz != 0) head = (d == 0) ? q0[0] : q1[0];
      er = !rst && (sz != 16);
      ev = !rst && (sz != 0) && ((d == 0) || (npk[d] != 0) || (sz == 16));
      chk(tg(d, "s_ready"),   16'(s_ready[d]),   16'(er));
      chk(tg(d, "m_valid"),   16'(m_valid[d]),   16'(ev));
      chk(tg(d, "level"),     16'(level[d]),     16'(sz));
      chk(tg(d, "pkt_count"), 16'(pkt_count[d]), 16'(npk[d]));
      chk(tg(d, "head"),      16'({m_last[d], m_data[d]}), 16'(ev ? head : 9'h000));
      if (ev && m_ready[d]) begin
        popped = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (popped[8]) npk[d]--;
      end
      if (er && s_valid[d]) begin
        if (d == 0) q0.push_back({s_last[d], s_data[d]});
        else        q1.push_back({s_last[d], s_data[d]});
        if (s_last[d]) npk[d]++;
        nwr[d]++;
      end
    end
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      npk[0] = 0;
      npk[1] = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
      s_data[d]  = 8'h00;
      m_ready[d] = 1'b0;
    end
  endtask

  initial begin
    int pk;
    int base;
    int n;

    rst = 1'b1;
    idle_inputs();
    npk[0] = 0; npk[1] = 0;
    nwr[0] = 0; nwr[1] = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk(tg(d, "rel_s_ready"),   16'(s_ready[d]),   16'd1);
      chk(tg(d, "rel_m_valid"),   16'(m_valid[d]),   16'd0);
      chk(tg(d, "rel_level"),     16'(level[d]),     16'd0);
      chk(tg(d, "rel_pkt_count"), 16'(pkt_count[d]), 16'd0);
      chk(tg(d, "rel_m_data"),    16'(m_data[d]),    16'd0);
    end

    // Three back-to-back bytes through the streaming instance.
    m_ready[0] = 1'b1;
    pk = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = 8'(17 * (i + 1));
      s_last[0]  = (i == 2);
      tick();
      if (i == 0) chk("d0_first_m_valid", 16'(m_valid[0]), 16'd1);
      if (int'(level[0]) > pk) pk = int'(level[0]);
    end
    idle_inputs();
    m_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (int'(level[0]) > pk) pk = int'(level[0]);
    end
    chk("d0_level_peak", 16'(pk), 16'd1);
    chk("d0_drained", 16'(q0.size()), 16'd0);

    // Fill to capacity, then offer a 17th byte while reading.
    m_ready[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = 8'(i);
      s_last[0]  = 1'b0;
      tick();
    end
    chk("d0_full_level",   16'(level[0]),   16'd16);
    chk("d0_full_s_ready", 16'(s_ready[0]), 16'd0);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h10;
    m_ready[0] = 1'b1;
    tick();
    chk("d0_no_wt_level",   16'(level[0]),   16'd15);
    chk("d0_no_wt_s_ready", 16'(s_ready[0]), 16'd1);
    s_valid[0] = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("d0_fill_drained", 16'(level[0]), 16'd0);

    // Bursty upstream (3 on / 2 off) against random downstream ready.
    base = nwr[0];
    n = 0;
    while ((nwr[0] - base) < 40 && n < 400) begin
      s_valid[0] = ((n % 5) < 3);
      s_data[0]  = 8'(8'h40 + (nwr[0] - base));
      s_last[0]  = (((nwr[0] - base) % 8) == 7);
      m_ready[0] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("d0_wrap_sent", 16'(nwr[0] - base), 16'd40);
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b1;
    n = 0;
    while (q0.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk("d0_wrap_drained", 16'(level[0]), 16'd0);
    idle_inputs();

    // Packet mode: nothing released until the last byte is stored.
    m_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid[1] = 1'b1;
      s_data[1]  = 8'(8'hA0 + i);
      s_last[1]  = (i == 3);
      tick();
      if (i < 3) chk("d1_hold_m_valid", 16'(m_valid[1]), 16'd0);
    end
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    chk("d1_pkt_m_valid",   16'(m_valid[1]),   16'd1);
    chk("d1_pkt_pkt_count", 16'(pkt_count[1]), 16'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("d1_pkt_drained_cnt", 16'(pkt_count[1]), 16'd0);
    chk("d1_pkt_drained_lvl", 16'(level[1]),     16'd0);

    // Over-long packet: full buffer releases data despite no complete packet.
    m_ready[1] = 1'b0;
    base = nwr[1];
    for (int i = 0; i < 16; i++) begin
      s_valid[1] = 1'b1;
      s_data[1]  = 8'(8'hB0 + i);
      s_last[1]  = 1'b0;
      tick();
    end
    chk("d1_full_level",     16'(level[1]),     16'd16);
    chk("d1_full_pkt_count", 16'(pkt_count[1]), 16'd0);
    chk("d1_full_m_valid",   16'(m_valid[1]),   16'd1);
    chk("d1_full_s_ready",   16'(s_ready[1]),   16'd0);
    m_ready[1] = 1'b1;
    n = 0;
    while ((nwr[1] - base) < 20 && n < 100) begin
      s_valid[1] = 1'b1;
      s_data[1]  = 8'(8'hB0 + (nwr[1] - base));
      s_last[1]  = ((nwr[1] - base) == 19);
      tick();
      n++;
    end
    chk("d1_long_sent", 16'(nwr[1] - base), 16'd20);
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("d1_middrain_m_valid", 16'(m_valid[1]), 16'd1);

    // Reset mid-drain with handshakes offered on both instances.
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b1;
      s_data[d]  = 8'h5A;
      s_last[d]  = 1'b1;
      m_ready[d] = 1'b1;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      chk(tg(d, "rst_m_valid"),   16'(m_valid[d]),   16'd0);
      chk(tg(d, "rst_m_data"),    16'(m_data[d]),    16'd0);
      chk(tg(d, "rst_m_last"),    16'(m_last[d]),    16'd0);
      chk(tg(d, "rst_s_ready"),   16'(s_ready[d]),   16'd0);
      chk(tg(d, "rst_level"),     16'(level[d]),     16'd0);
      chk(tg(d, "rst_pkt_count"), 16'(pkt_count[d]), 16'd0);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("d1_after_rst_s_ready", 16'(s_ready[1]), 16'd1);
    chk("d1_after_rst_level",   16'(level[1]),   16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis8_pkt_fifo.md
Name: axis8_pkt_fifo

Overview:
- Synchronous 8-bit AXI-Stream FIFO that stores data with its last flag.
- Sits directly downstream of the 8-bit AXI register stage. It absorbs that stage's bursty valid/ready pattern and presents a clean stream to the next consumer.
- Optional packet mode holds off output until a complete packet (or a full buffer) is stored.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.
- PKT_MODE, 0, 0 = forward bytes as soon as stored; 1 = release only when a whole packet is buffered.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  input byte.
- s_valid  in  1  input byte valid.
- s_ready  out  1  FIFO can accept a byte.
- s_last  in  1  input byte is the final byte of a packet.
- m_data  out  8  head byte.
- m_valid  out  1  head byte valid.
- m_ready  in  1  downstream accepts the head byte.
- m_last  out  1  last flag of the head byte.
- level  out  ADDR_W+1  current number of stored entries.
- pkt_count  out  ADDR_W+1  number of complete packets (last-flagged bytes) stored.

Behaviour:
- Storage: DEPTH x 9-bit entries {last, data}; memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH. level is tracked explicitly, range 0..DEPTH.
- full: level == DEPTH. empty: level == 0.
- s_ready is combinational: !full && !rst.
- Write fires when s_valid && s_ready at a clock edge; the entry is stored at wr_ptr and wr_ptr increments.
- Read fires when m_valid && m_ready at a clock edge; rd_ptr increments.
- Output is first-word-fall-through:
  - m_data/m_last come combinationally from mem[rd_ptr].
  - Both are forced to 0 whenever m_valid = 0.
- m_valid:
  - PKT_MODE = 0: !empty.
  - PKT_MODE = 1: !empty && (pkt_count != 0 || full).
  - The full override prevents deadlock on packets longer than DEPTH.
- Latency: a byte written at edge N is visible (m_valid = 1) after edge N (PKT_MODE = 0), and can be read at edge N+1 at the earliest. There is no combinational path from s_* to m_*.
- Simultaneous read and write when not full: level is unchanged and both pointers advance.
- When full, s_ready = 0 even if a read fires in the same cycle; no write-through on full.
- When empty, no read is possible; m_ready is ignored.
- pkt_count:
  - +1 on a write with s_last = 1.
  - -1 on a read with m_last = 1.
  - Both in the same cycle: unchanged.
  - Never exceeds level.
- Reset, including mid-packet or mid-transfer:
  - Next edge: wr_ptr = rd_ptr = 0, level = 0, pkt_count = 0.
  - Therefore m_valid = 0, m_data = 0, m_last = 0, s_ready = 0 while rst is high and 1 from the first cycle after rst falls.
  - A partially stored packet is discarded.
- A handshake offered in the same cycle as rst is not performed.
- Data ordering is strictly preserved; no byte is dropped or duplicated.

Decomposition:
- Shared package axis8_pkg: AXIS8_DATA_W = 8, AXIS8_ENTRY_W = 9, and the entry struct/typedef {last, data}.
- One natural sub-module: axis8_fifo_mem, a DEPTH x 9 simple dual-port RAM (synchronous write, asynchronous read) so it can be swapped for a vendor RAM.
- Pointer, level and pkt_count logic stay in the top.

Test Plan:
- Reset then idle: after rst is released, s_ready = 1, m_valid = 0, level = 0, pkt_count = 0, m_data = 0.
- PKT_MODE = 0, m_ready = 1, write 0x11, 0x22, 0x33 (last on 0x33) back-to-back: m_valid rises the cycle after the first write; output is 0x11, 0x22, 0x33 with m_last only on 0x33; level peaks at 1.
- Fill: m_ready = 0, write 16 bytes 0x00..0x0F: level = 16 and s_ready = 0. Offer a 17th byte while reading one in the same cycle: the 17th is not accepted and level = 15. Next cycle s_ready = 1.
- Wrap-around: stream 40 bytes with a random m_ready duty cycle (upstream ready pattern of 3 on / 2 off): output equals input in order, pointers wrap twice, no loss.
- PKT_MODE = 1, write 0xA0, 0xA1, 0xA2 without last: m_valid stays 0. Write 0xA3 with last: m_valid = 1 next cycle and pkt_count = 1. Drain all 4 bytes: pkt_count returns to 0.
- PKT_MODE = 1 with a 20-byte packet: at level = 16 with pkt_count = 0, m_valid asserts (full override) and the stream drains without deadlock. Assert rst mid-drain: all outputs return to reset values on the next edge.
